// File: rtl/layer1_accumulator.sv
// Layer-1 neuron accumulator: streams pixels against per-node weights through a
// two-stage multiply/saturating-add pipeline and presents the final sums with a level trigger.
module layer1_accumulator #(
    parameter int NODES      = 4,
    parameter int NUM_INPUTS = 784,
    parameter int PIX_WIDTH  = 8,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NODES*ACC_WIDTH-1:0]   biasIn,
    input  logic [PIX_WIDTH-1:0]         pixelIn,
    input  logic [NODES*W_WIDTH-1:0]     weightsIn,
    input  logic                         pixelValid,
    output logic                         pixelReady,
    output logic [NODES*ACC_WIDTH-1:0]   sumIn,
    output logic                         trigger,
    input  logic                         consume,
    output logic                         busy
);

    localparam int PROD_W = PIX_WIDTH + W_WIDTH + 1;
    localparam int CNT_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        drain_q, drain_d;
    logic                        prod_valid_q, prod_valid_d;
    logic signed [PROD_W-1:0]    prod_q [NODES];
    logic signed [PROD_W-1:0]    prod_d [NODES];
    logic signed [ACC_WIDTH-1:0] acc_q [NODES];
    logic signed [ACC_WIDTH-1:0] acc_d [NODES];
    logic                        accept_s;
    logic                        load_s;

    // Pixel is unsigned, so it is zero-extended before the signed multiply.
    function automatic logic signed [PROD_W-1:0] mul_px(
        input logic [PIX_WIDTH-1:0]      px,
        input logic signed [W_WIDTH-1:0] w
    );
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = {{(PROD_W-PIX_WIDTH){1'b0}}, px};
        b = {{(PROD_W-W_WIDTH){w[W_WIDTH-1]}}, w};
        return a * b;
    endfunction

    // One guard bit exposes overflow; the guard bit carries the true sign for the clamp.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [PROD_W-1:0]    p
    );
        logic signed [ACC_WIDTH:0]    s;
        logic signed [ACC_WIDTH-1:0]  r;
        s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(p);
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            r = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            r = s[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // Next-state, counters and pipeline datapath.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        drain_d      = 1'b0;
        prod_d       = prod_q;
        acc_d        = acc_q;
        accept_s     = (state_q == S_ACCUM) && pixelValid;
        load_s       = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        prod_valid_d = accept_s;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ACCUM;
                else       state_d = S_IDLE;
            end
            S_ACCUM: begin
                if (accept_s && (cnt_q == LAST_IDX)) state_d = S_DRAIN;
                else                                  state_d = S_ACCUM;
            end
            S_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) state_d = S_DONE;
                else         state_d = S_DRAIN;
            end
            S_DONE: begin
                if (start)        state_d = S_ACCUM;
                else if (consume) state_d = S_IDLE;
                else              state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_d = (cnt_q == LAST_IDX) ? {CNT_W{1'b0}} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end

        for (int k = 0; k < NODES; k++) begin
            if (accept_s) begin
                prod_d[k] = mul_px(pixelIn, weightsIn[k*W_WIDTH +: W_WIDTH]);
            end else begin
                prod_d[k] = prod_q[k];
            end
            if (load_s) begin
                acc_d[k] = biasIn[k*ACC_WIDTH +: ACC_WIDTH];
            end else if (prod_valid_q) begin
                acc_d[k] = sat_add(acc_q[k], prod_q[k]);
            end else begin
                acc_d[k] = acc_q[k];
            end
        end
    end

    // State, pipeline and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            drain_q      <= 1'b0;
            prod_valid_q <= 1'b0;
            for (int k = 0; k < NODES; k++) begin
                prod_q[k] <= {PROD_W{1'b0}};
                acc_q[k]  <= {ACC_WIDTH{1'b0}};
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            prod_valid_q <= prod_valid_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
        end
    end

    // Outputs decode registered state and accumulators only.
    always_comb begin
        sumIn      = {(NODES*ACC_WIDTH){1'b0}};
        pixelReady = (state_q == S_ACCUM);
        trigger    = (state_q == S_DONE);
        busy       = (state_q != S_IDLE);
        for (int k = 0; k < NODES; k++) begin
            sumIn[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k];
        end
    end

endmodule

// File: tb/tb_layer1_accumulator.sv
// Directed bench for layer1_accumulator (2 nodes, 4 pixels, 16-bit sums) with a
// trigger-driven scoreboard monitor.
module tb_layer1_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] biasIn;
    logic [7:0]  pixelIn;
    logic [15:0] weightsIn;
    logic        pixelValid;
    logic        pixelReady;
    logic [31:0] sumIn;
    logic        trigger;
    logic        consume;
    logic        busy;

    int          ntests;
    int          nfail;
    logic [31:0] exp_q[$];
    logic        trig_prev;

    layer1_accumulator #(
        .NODES(2), .NUM_INPUTS(4), .PIX_WIDTH(8), .W_WIDTH(8), .ACC_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .biasIn(biasIn),
        .pixelIn(pixelIn), .weightsIn(weightsIn), .pixelValid(pixelValid),
        .pixelReady(pixelReady), .sumIn(sumIn), .trigger(trigger),
        .consume(consume), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each rising trigger must present the oldest expected sums.
    always @(negedge clk) begin
        if (rst_n && trigger && !trig_prev) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_trigger", 32'sd1, 32'sd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sum_node0", $signed(sumIn[15:0]), $signed(e[15:0]));
                check("sum_node1", $signed(sumIn[31:16]), $signed(e[31:16]));
            end
        end
        trig_prev <= trigger;
    end

    task automatic begin_frame(input logic [15:0] b0, input logic [15:0] b1, input logic with_consume);
        biasIn  = {b1, b0};
        start   = 1'b1;
        consume = with_consume;
        @(posedge clk); #1;
        start   = 1'b0;
        consume = 1'b0;
        check("frame_busy", busy, 1);
        check("frame_ready", pixelReady, 1);
        check("frame_trig_low", trigger, 0);
        check("bias_node0", $signed(sumIn[15:0]), $signed(b0));
        check("bias_node1", $signed(sumIn[31:16]), $signed(b1));
    endtask

    task automatic feed(input logic [31:0] pix, input logic [31:0] w0s, input logic [31:0] w1s,
                        input int gap, input logic ign, input logic [31:0] expv);
        for (int i = 0; i < 4; i++) begin
            check("ready_accum", pixelReady, 1);
            pixelValid = 1'b1;
            pixelIn    = pix[8*i +: 8];
            weightsIn  = {w1s[8*i +: 8], w0s[8*i +: 8]};
            if (i == 3) exp_q.push_back(expv);
            @(posedge clk); #1;
            pixelValid = 1'b0;
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    check("ready_bubble", pixelReady, 1);
                    start = ign && (i == 0) && (g == 0);
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
        end
        // Last pixel accepted: two drain cycles, then trigger.
        check("drain_trig0", trigger, 0);
        check("drain_not_ready", pixelReady, 0);
        start = ign;
        @(posedge clk); #1;
        start = 1'b0;
        check("drain_trig1", trigger, 0);
        @(posedge clk); #1;
        check("trig_rise", trigger, 1);
    endtask

    task automatic finish_done(input int hold, input logic [31:0] expv);
        for (int h = 0; h < hold; h++) begin
            check("hold_trig", trigger, 1);
            check("hold_sum", sumIn, expv);
            @(posedge clk); #1;
        end
        consume = 1'b1;
        @(posedge clk); #1;
        consume = 1'b0;
        check("consume_trig", trigger, 0);
        check("consume_idle", busy, 0);
    endtask

    initial begin
        ntests = 0; nfail = 0; trig_prev = 1'b0;
        clk = 1'b0; rst_n = 1'b1; start = 1'b0; consume = 1'b0;
        biasIn = 32'd0; pixelIn = 8'd0; weightsIn = 16'd0; pixelValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_trigger", trigger, 0);
        check("rst_ready", pixelReady, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sumIn, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        // Nominal: pixels 1..4, weights {+1,-1}, bias {0,10} -> {10,0}
        begin_frame(16'd0, 16'd10, 1'b0);
        feed(32'h04030201, 32'h01010101, 32'hFFFFFFFF, 0, 1'b0, 32'h0000_000A);
        finish_done(10, 32'h0000_000A);

        // Same frame with two-cycle bubbles
        begin_frame(16'd0, 16'd10, 1'b0);
        feed(32'h04030201, 32'h01010101, 32'hFFFFFFFF, 2, 1'b0, 32'h0000_000A);
        finish_done(1, 32'h0000_000A);

        // Start pulsed in ACCUM and DRAIN must be ignored
        begin_frame(16'd0, 16'd10, 1'b0);
        feed(32'h04030201, 32'h01010101, 32'hFFFFFFFF, 1, 1'b1, 32'h0000_000A);

        // Start with consume in DONE: saturation frame 255*127 / 255*-128
        begin_frame(16'sd32700, -16'sd32700, 1'b1);
        feed(32'hFFFFFFFF, 32'h7F7F7F7F, 32'h80808080, 0, 1'b0, 32'h8000_7FFF);
        finish_done(1, 32'h8000_7FFF);

        // Clamped accumulators keep adding normally: {32766, -32767}
        begin_frame(16'sd32700, -16'sd32700, 1'b0);
        feed(32'h01FF01FF, 32'hFF7FFF7F, 32'h01800180, 0, 1'b0, 32'h8001_7FFE);
        finish_done(1, 32'h8001_7FFE);

        // Reset after the second pixel, with a product still in flight
        begin_frame(16'd100, -16'sd100, 1'b0);
        for (int i = 0; i < 2; i++) begin
            pixelValid = 1'b1; pixelIn = 8'd50; weightsIn = 16'h0101;
            @(posedge clk); #1;
            pixelValid = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_trigger", trigger, 0);
        check("midrst_ready", pixelReady, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sumIn, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle", busy, 0);
        @(posedge clk); #1;
        check("postrst_still_idle", busy, 0);

        // Fresh frame: bias {5,-3} -> {28,-14}
        begin_frame(16'd5, -16'sd3, 1'b0);
        feed(32'h01070002, 32'h0A01FC03, 32'hF90005FE, 0, 1'b0, 32'hFFF2_001C);
        finish_done(2, 32'hFFF2_001C);

        @(posedge clk); #1;
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
